// File: rtl/mux_frecuencias_pkg.sv
// Shared FSM state type and default sizing for the switching-frequency multiplexer.
package mux_frecuencias_pkg;

    localparam int unsigned N_CLK_DEF   = 8;
    localparam int unsigned TIMEOUT_DEF = 1024;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        GATE
    } fsm_state_t;

endpackage

// File: rtl/mux_frecuencias_gf_if.sv
// Bus between the frequency source/control side and the glitch-free multiplexer.
interface mux_frecuencias_gf_if
    import mux_frecuencias_pkg::*;
#(
    parameter int unsigned N_CLK = N_CLK_DEF,
    parameter int unsigned SEL_W = $clog2(N_CLK)
);

    logic [N_CLK-1:0] Clock_out;
    logic [SEL_W-1:0] Selector;
    logic             Enable;
    logic             Fsw;
    logic [SEL_W-1:0] Sel_active;
    logic             Busy;
    logic             Switch_done;
    logic             Timeout_err;

    modport master (
        output Clock_out, Selector, Enable,
        input  Fsw, Sel_active, Busy, Switch_done, Timeout_err
    );

    modport slave (
        input  Clock_out, Selector, Enable,
        output Fsw, Sel_active, Busy, Switch_done, Timeout_err
    );

endinterface

// File: rtl/fsw_wait_timer.sv
// Bounded wait counter for the switch-over states; saturates at TIMEOUT-1.
module fsw_wait_timer
    import mux_frecuencias_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CNT_W   = $clog2(TIMEOUT)
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    assign expired = (cnt_q == LAST);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/mux_frecuencias_gf.sv
// Glitch-free selector among N_CLK divided frequencies: the old source is drained to a
// low level, the output is gated low, and the new source is only admitted while low.
module mux_frecuencias_gf
    import mux_frecuencias_pkg::*;
#(
    parameter int unsigned N_CLK   = N_CLK_DEF,
    parameter int unsigned SEL_W   = $clog2(N_CLK),
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input logic           Clk,
    input logic           Reset_n,
    mux_frecuencias_gf_if.slave bus
);

    localparam logic [SEL_W:0] N_CLK_LIM = (SEL_W + 1)'(N_CLK);

    fsm_state_t       state_q, state_d;
    logic             fsw_q, fsw_d;
    logic [SEL_W-1:0] sel_active_q, sel_active_d;
    logic [SEL_W-1:0] pending_q, pending_d;
    logic             done_q, done_d;
    logic             tout_q, tout_d;
    logic             busy;
    logic             timer_clear;
    logic             timer_expired;
    logic             sel_valid;
    logic             src_act;
    logic             src_pend;

    assign sel_valid = ({1'b0, bus.Selector} < N_CLK_LIM);
    assign src_act   = bus.Clock_out[sel_active_q];
    assign src_pend  = bus.Clock_out[pending_q];
    assign busy      = (state_q == DRAIN) || (state_q == GATE);

    fsw_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clear   (timer_clear),
        .enable  (busy),
        .expired (timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        fsw_d        = 1'b0;
        sel_active_d = sel_active_q;
        pending_d    = pending_q;
        done_d       = 1'b0;
        tout_d       = 1'b0;
        timer_clear  = 1'b0;

        if (!bus.Enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // An out-of-range request on enable resumes the last valid source.
                    pending_d = sel_valid ? bus.Selector : sel_active_q;
                    state_d   = GATE;
                end
                RUN: begin
                    fsw_d = src_act;
                    if (sel_valid && (bus.Selector != sel_active_q)) begin
                        pending_d = bus.Selector;
                        state_d   = DRAIN;
                    end
                end
                DRAIN: begin
                    if (sel_valid && (bus.Selector == sel_active_q)) begin
                        fsw_d   = src_act;
                        state_d = RUN;
                    end else begin
                        if (sel_valid && (bus.Selector != pending_q)) begin
                            pending_d   = bus.Selector;
                            timer_clear = 1'b1;
                        end
                        if (!src_act) begin
                            state_d = GATE;
                        end else if (timer_expired && !timer_clear) begin
                            state_d = GATE;
                            tout_d  = 1'b1;
                        end else begin
                            fsw_d = src_act;
                        end
                    end
                end
                GATE: begin
                    if (sel_valid && (bus.Selector != pending_q)) begin
                        pending_d   = bus.Selector;
                        timer_clear = 1'b1;
                    end else if (!src_pend || timer_expired) begin
                        sel_active_d = pending_q;
                        done_d       = 1'b1;
                        tout_d       = src_pend;
                        state_d      = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Every state change restarts the wait budget for the next waiting phase.
        timer_clear = timer_clear | (state_d != state_q);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            fsw_q        <= 1'b0;
            sel_active_q <= '0;
            pending_q    <= '0;
            done_q       <= 1'b0;
            tout_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fsw_q        <= fsw_d;
            sel_active_q <= sel_active_d;
            pending_q    <= pending_d;
            done_q       <= done_d;
            tout_q       <= tout_d;
        end
    end

    assign bus.Fsw         = fsw_q;
    assign bus.Sel_active  = sel_active_q;
    assign bus.Busy        = busy;
    assign bus.Switch_done = done_q;
    assign bus.Timeout_err = tout_q;

endmodule

// File: tb/tb_mux_frecuencias_gf.sv
// Directed-vector bench for mux_frecuencias_gf with N_CLK=6, TIMEOUT=16.
module tb_mux_frecuencias_gf;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mux_frecuencias_gf_if #(.N_CLK(6)) bus ();

    mux_frecuencias_gf #(
        .N_CLK   (6),
        .TIMEOUT (16)
    ) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one input vector, clock it, then compare all outputs just after the edge.
    task automatic vec(input string tag, input logic [5:0] co, input logic [2:0] sel,
                       input logic en, input logic e_fsw, input logic e_busy,
                       input logic e_done, input logic e_tout, input logic [2:0] e_act);
        bus.Clock_out = co;
        bus.Selector  = sel;
        bus.Enable    = en;
        @(posedge clk);
        #1;
        check({tag, ".fsw"},  bus.Fsw,         e_fsw);
        check({tag, ".busy"}, bus.Busy,        e_busy);
        check({tag, ".done"}, bus.Switch_done, e_done);
        check({tag, ".tout"}, bus.Timeout_err, e_tout);
        check({tag, ".act"},  bus.Sel_active,  e_act);
    endtask

    initial begin
        rst_n = 1'b0;
        // reset dominates even with enable and sources high
        vec("rst0", 6'b111111, 3'd3, 1'b1, 0, 0, 0, 0, 3'd0);
        vec("rst1", 6'b111111, 3'd3, 1'b1, 0, 0, 0, 0, 3'd0);
        rst_n = 1'b1;

        // enable with Selector=3, bit 3 low: done two cycles later
        vec("en_gate",  6'b000000, 3'd3, 1'b1, 0, 1, 0, 0, 3'd0);
        vec("en_done",  6'b000000, 3'd3, 1'b1, 0, 0, 1, 0, 3'd3);
        // tracking bit 3, other bits inverted
        vec("trk0",     6'b001000, 3'd3, 1'b1, 1, 0, 0, 0, 3'd3);
        vec("trk1",     6'b001000, 3'd3, 1'b1, 1, 0, 0, 0, 3'd3);
        vec("trk2",     6'b110111, 3'd3, 1'b1, 0, 0, 0, 0, 3'd3);
        vec("trk3",     6'b001000, 3'd3, 1'b1, 1, 0, 0, 0, 3'd3);
        vec("trk4",     6'b110111, 3'd3, 1'b1, 0, 0, 0, 0, 3'd3);

        // move to index 0
        vec("to0_dr",   6'b000000, 3'd0, 1'b1, 0, 1, 0, 0, 3'd3);
        vec("to0_gt",   6'b000000, 3'd0, 1'b1, 0, 1, 0, 0, 3'd3);
        vec("to0_done", 6'b000000, 3'd0, 1'b1, 0, 0, 1, 0, 3'd0);
        vec("to0_run",  6'b000000, 3'd0, 1'b1, 0, 0, 0, 0, 3'd0);

        // 0 -> 5 while bit 0 high (period 4), bit 5 high while gated
        vec("sw5_t0",   6'b000001, 3'd5, 1'b1, 1, 1, 0, 0, 3'd0);
        vec("sw5_t1",   6'b000001, 3'd5, 1'b1, 1, 1, 0, 0, 3'd0);
        vec("sw5_t2",   6'b100000, 3'd5, 1'b1, 0, 1, 0, 0, 3'd0);
        vec("sw5_t3",   6'b100000, 3'd5, 1'b1, 0, 1, 0, 0, 3'd0);
        vec("sw5_t4",   6'b100001, 3'd5, 1'b1, 0, 1, 0, 0, 3'd0);
        vec("sw5_t5",   6'b000001, 3'd5, 1'b1, 0, 0, 1, 0, 3'd5);
        vec("sw5_t6",   6'b100000, 3'd5, 1'b1, 1, 0, 0, 0, 3'd5);
        vec("sw5_t7",   6'b100000, 3'd5, 1'b1, 1, 0, 0, 0, 3'd5);
        vec("sw5_t8",   6'b000001, 3'd5, 1'b1, 0, 0, 0, 0, 3'd5);

        // abort in DRAIN: selector returns to the active index
        vec("abort_dr", 6'b100000, 3'd1, 1'b1, 1, 1, 0, 0, 3'd5);
        vec("abort_rn", 6'b100000, 3'd5, 1'b1, 1, 0, 0, 0, 3'd5);
        vec("abort_tk", 6'b000010, 3'd5, 1'b1, 0, 0, 0, 0, 3'd5);

        // move to index 2
        vec("to2_dr",   6'b000000, 3'd2, 1'b1, 0, 1, 0, 0, 3'd5);
        vec("to2_gt",   6'b000000, 3'd2, 1'b1, 0, 1, 0, 0, 3'd5);
        vec("to2_done", 6'b000000, 3'd2, 1'b1, 0, 0, 1, 0, 3'd2);

        // bit 2 stuck high, 2 -> 4: DRAIN times out on the 16th busy cycle
        vec("tod_ent",  6'b000100, 3'd4, 1'b1, 1, 1, 0, 0, 3'd2);
        for (int i = 0; i < 15; i++)
            vec("tod_wait", 6'b000100, 3'd4, 1'b1, 1, 1, 0, 0, 3'd2);
        vec("tod_err",  6'b000100, 3'd4, 1'b1, 0, 1, 0, 1, 3'd2);
        vec("tod_done", 6'b000100, 3'd4, 1'b1, 0, 0, 1, 0, 3'd4);

        // 4 -> 2 with bit 2 stuck high: GATE timeout, done and error together
        vec("tog_dr",   6'b000100, 3'd2, 1'b1, 0, 1, 0, 0, 3'd4);
        vec("tog_gt",   6'b000100, 3'd2, 1'b1, 0, 1, 0, 0, 3'd4);
        for (int i = 0; i < 15; i++)
            vec("tog_wait", 6'b000100, 3'd2, 1'b1, 0, 1, 0, 0, 3'd4);
        vec("tog_both", 6'b000100, 3'd2, 1'b1, 0, 0, 1, 1, 3'd2);
        vec("tog_run",  6'b000100, 3'd2, 1'b1, 1, 0, 0, 0, 3'd2);

        // out-of-range selectors ignored in RUN
        vec("bad7",     6'b000100, 3'd7, 1'b1, 1, 0, 0, 0, 3'd2);
        vec("bad6",     6'b000000, 3'd6, 1'b1, 0, 0, 0, 0, 3'd2);

        // reset while draining
        vec("rdr_dr",   6'b000100, 3'd0, 1'b1, 1, 1, 0, 0, 3'd2);
        rst_n = 1'b0;
        vec("rdr_rst",  6'b000100, 3'd0, 1'b1, 0, 0, 0, 0, 3'd0);
        rst_n = 1'b1;

        // restart to index 3, then Enable=0 while gated
        vec("re_gt",    6'b000000, 3'd3, 1'b1, 0, 1, 0, 0, 3'd0);
        vec("re_done",  6'b000000, 3'd3, 1'b1, 0, 0, 1, 0, 3'd3);
        vec("dis_dr",   6'b001000, 3'd0, 1'b1, 1, 1, 0, 0, 3'd3);
        vec("dis_gt",   6'b000001, 3'd0, 1'b1, 0, 1, 0, 0, 3'd3);
        vec("dis_bad7", 6'b000001, 3'd7, 1'b1, 0, 1, 0, 0, 3'd3);
        vec("dis_off",  6'b000001, 3'd0, 1'b0, 0, 0, 0, 0, 3'd3);
        vec("dis_hold", 6'b111111, 3'd0, 1'b0, 0, 0, 0, 0, 3'd3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_frecuencias_gf.md
MUX_FRECUENCIAS_GF -- requirements
Module: mux_frecuencias_gf

Interface
REQ-001 SHALL have parameter N_CLK, default 8, number of candidate switching frequencies (2..64).
REQ-002 SHALL have parameter SEL_W, default $clog2(N_CLK), selector width (derived, not overridden).
REQ-003 SHALL have parameter TIMEOUT, default 1024, max Clk cycles waited for a safe low level.
REQ-004 SHALL have port Clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port Reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port Clock_out  input  N_CLK  divided frequencies, synchronous to Clk.
REQ-007 SHALL have port Selector  input  SEL_W  requested frequency index.
REQ-008 SHALL have port Enable  input  1  1 = output running, 0 = Fsw forced low.
REQ-009 SHALL have port Fsw  output  1  registered, glitch-free selected frequency.
REQ-010 SHALL have port Sel_active  output  SEL_W  index currently driving Fsw.
REQ-011 SHALL have port Busy  output  1  high while a switch-over is in progress.
REQ-012 SHALL have port Switch_done  output  1  one-cycle pulse when a new index takes effect.
REQ-013 SHALL have port Timeout_err  output  1  one-cycle pulse when a wait is abandoned at TIMEOUT.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DRAIN, GATE.
REQ-015 IDLE: Fsw=0; on Enable=1 latch pending=Selector, go GATE.
REQ-016 RUN: Fsw <= Clock_out[Sel_active] (latency 1 cycle); if Selector != Sel_active and Selector < N_CLK, latch pending, go DRAIN.
REQ-017 DRAIN: Fsw keeps following old source; when Clock_out[Sel_active]==0, Fsw <= 0 and go GATE.
REQ-018 GATE: Fsw held 0; when Clock_out[pending]==0, Sel_active <= pending, pulse Switch_done, go RUN.
REQ-019 Selector change during DRAIN or GATE SHALL update pending; wait counter restarts.
REQ-020 Selector returning to Sel_active during DRAIN SHALL abort to RUN with no gap and no Switch_done.
REQ-021 Selector >= N_CLK (non-power-of-2 N_CLK) SHALL be ignored in every state.
REQ-022 Enable=0 in any state SHALL force Fsw <= 0 next cycle, go IDLE, keep Sel_active.
REQ-023 Wait counter counts cycles in DRAIN+GATE; at TIMEOUT-1 it SHALL force the pending transition (DRAIN->GATE or GATE->RUN) and pulse Timeout_err.
REQ-024 Busy SHALL be 1 exactly in DRAIN and GATE.
REQ-025 Fsw SHALL never show a high pulse shorter than the source high time (no runt pulses).
REQ-026 Switch_done and Timeout_err in same cycle allowed (timeout in GATE).

Reset
REQ-027 Reset_n=0 at a Clk edge SHALL set state IDLE, Fsw=0, Sel_active=0, pending=0, counter=0, Busy=0, Switch_done=0, Timeout_err=0.
REQ-028 Reset mid-switch SHALL abandon the switch without pulses.

Structure
REQ-029 Shared package mux_frecuencias_pkg SHALL hold the FSM state enum and default N_CLK/TIMEOUT constants.
REQ-030 The wait counter SHALL be sub-module fsw_wait_timer (clear, enable, expiry flag, width $clog2(TIMEOUT)).

Verification
REQ-031 Reset, Enable=1, Selector=3, Clock_out[3] low -> Switch_done after 2 cycles, Sel_active=3, Fsw tracks bit 3 at latency 1.
REQ-032 Running idx 0 (period 4), Selector->5 while bit0 high -> Fsw stays high till bit0 falls, low until bit5 low, Switch_done, Sel_active=5, no runt.
REQ-033 In DRAIN, Selector back to 0 -> Busy drops next cycle, Fsw uninterrupted, no Switch_done.
REQ-034 Bit 2 stuck high, TIMEOUT=16, switch 2->4 -> Timeout_err at 16th Busy cycle, switch completes.
REQ-035 N_CLK=6, Selector=7 -> no state change; Enable=0 mid-GATE -> IDLE, Fsw=0; Reset_n=0 in DRAIN -> all outputs reset values.
